// File: rtl/scale_sweep_ctrl_pkg.sv
// Shared types and widths for the scale sweep controller.
// Boundary mode is selected by SCALE_SWEEP_PINGPONG_EN (see scale_sweep_ctrl).
package scale_sweep_ctrl_pkg;

   localparam int unsigned SCALE_W = 6;

   typedef enum logic [1:0] {
      MANUAL     = 2'd0,
      SWEEP_UP   = 2'd1,
      SWEEP_DOWN = 2'd2
   } sweep_state_t;

endpackage

// File: rtl/scale_sweep_ctrl_dwell_timer.sv
// Dwell counter: counts 0..DWELL_CYCLES-1 while run is high, tick on terminal count.
// clear has priority over run and suppresses tick.
module dwell_timer #(
   parameter int unsigned DWELL_CYCLES = 50000000
) (
   input  logic sysclk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = run && !clear && (cnt == TERM);

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/scale_sweep_ctrl.sv
// Frequency scale controller: manual +/- stepping or timed auto sweep.
// Define SCALE_SWEEP_PINGPONG_EN to bounce at the limits instead of wrapping.
module scale_sweep_ctrl
   import scale_sweep_ctrl_pkg::*;
#(
   parameter int unsigned SCALE_MAX    = 63,
   parameter int unsigned SCALE_MIN    = 0,
   parameter int unsigned DWELL_CYCLES = 50000000
) (
   input  logic               sysclk,
   input  logic               reset,
   input  logic               plus_pulse,
   input  logic               minus_pulse,
   input  logic               auto_en,
   input  logic               hold,
   output logic [SCALE_W-1:0] scale,
   output logic               scale_upd,
   output logic               sweep_dir
);

   localparam logic [SCALE_W-1:0] S_MAX = SCALE_W'(SCALE_MAX);
   localparam logic [SCALE_W-1:0] S_MIN = SCALE_W'(SCALE_MIN);

   sweep_state_t       state, state_nxt;
   logic [SCALE_W-1:0] scale_nxt;
   logic               btn_up, btn_dn, in_sweep;
   logic               dwell_clear, dwell_run, step;

   assign btn_up   = plus_pulse & ~minus_pulse;
   assign btn_dn   = minus_pulse & ~plus_pulse;
   assign in_sweep = (state != MANUAL);

   // Any state change or button in a sweep restarts the dwell; this also makes buttons beat a coinciding tick.
   assign dwell_clear = !in_sweep || !auto_en || btn_up || btn_dn;
   assign dwell_run   = !hold;

   dwell_timer #(
      .DWELL_CYCLES(DWELL_CYCLES)
   ) u_dwell (
      .sysclk(sysclk),
      .reset (reset),
      .clear (dwell_clear),
      .run   (dwell_run),
      .tick  (step)
   );

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state <= MANUAL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MANUAL: begin
            if (auto_en) state_nxt = SWEEP_UP;
         end
         SWEEP_UP, SWEEP_DOWN: begin
            if (!auto_en) begin
               state_nxt = MANUAL;
            end else if (btn_up) begin
               state_nxt = SWEEP_UP;
            end else if (btn_dn) begin
               state_nxt = SWEEP_DOWN;
            end else if (step) begin
`ifdef SCALE_SWEEP_PINGPONG_EN
               if (state == SWEEP_UP && scale >= S_MAX) state_nxt = SWEEP_DOWN;
               if (state == SWEEP_DOWN && scale <= S_MIN) state_nxt = SWEEP_UP;
`endif
            end
         end
         default: state_nxt = MANUAL;
      endcase
   end

   always_comb begin
      sweep_dir = (state != SWEEP_DOWN);
   end

   always_comb begin
      scale_nxt = scale;
      case (state)
         MANUAL: begin
            if (!auto_en) begin
               if (btn_up && scale < S_MAX) scale_nxt = scale + 1'b1;
               if (btn_dn && scale > S_MIN) scale_nxt = scale - 1'b1;
            end
         end
         SWEEP_UP: begin
            if (step) begin
`ifdef SCALE_SWEEP_PINGPONG_EN
               scale_nxt = (scale >= S_MAX) ? S_MAX - 1'b1 : scale + 1'b1;
`else
               scale_nxt = (scale >= S_MAX) ? S_MIN : scale + 1'b1;
`endif
            end
         end
         SWEEP_DOWN: begin
            if (step) begin
`ifdef SCALE_SWEEP_PINGPONG_EN
               scale_nxt = (scale <= S_MIN) ? S_MIN + 1'b1 : scale - 1'b1;
`else
               scale_nxt = (scale <= S_MIN) ? S_MAX : scale - 1'b1;
`endif
            end
         end
         default: scale_nxt = scale;
      endcase
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         scale     <= S_MIN;
         scale_upd <= 1'b0;
      end else begin
         scale     <= scale_nxt;
         scale_upd <= (scale_nxt != scale);
      end
   end

endmodule

// File: tb/tb_scale_sweep_ctrl.sv
// Directed bench for scale_sweep_ctrl with DWELL_CYCLES=4, range 0..63.
// Boundary expectations follow SCALE_SWEEP_PINGPONG_EN when defined.
module tb_scale_sweep_ctrl;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b1;
   logic       plus_pulse = 1'b0;
   logic       minus_pulse = 1'b0;
   logic       auto_en = 1'b0;
   logic       hold = 1'b0;
   logic [5:0] scale;
   logic       scale_upd;
   logic       sweep_dir;

   int total = 0;
   int bad   = 0;

   scale_sweep_ctrl #(
      .SCALE_MAX   (63),
      .SCALE_MIN   (0),
      .DWELL_CYCLES(4)
   ) dut (
      .sysclk     (sysclk),
      .reset      (reset),
      .plus_pulse (plus_pulse),
      .minus_pulse(minus_pulse),
      .auto_en    (auto_en),
      .hold       (hold),
      .scale      (scale),
      .scale_upd  (scale_upd),
      .sweep_dir  (sweep_dir)
   );

   always #5 sysclk = ~sysclk;

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic do_reset();
      plus_pulse = 1'b0; minus_pulse = 1'b0; auto_en = 1'b0; hold = 1'b0;
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic press_plus(input int n);
      for (int i = 0; i < n; i++) begin
         plus_pulse = 1'b1;
         step();
         plus_pulse = 1'b0;
         step();
      end
   endtask

   task automatic test_reset();
      #3 reset = 1'b0;
      #1;
      total++; if (scale !== 6'd0)     begin bad++; $display("FAIL reset_scale: got %0d want 0", scale); end
      total++; if (scale_upd !== 1'b0) begin bad++; $display("FAIL reset_upd: got %0d want 0", scale_upd); end
      total++; if (sweep_dir !== 1'b1) begin bad++; $display("FAIL reset_dir: got %0d want 1", sweep_dir); end
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_manual();
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         plus_pulse = 1'b1;
         step();
         plus_pulse = 1'b0;
         total++; if (scale !== 6'(k))    begin bad++; $display("FAIL manual_plus_scale: got %0d want %0d", scale, k); end
         total++; if (scale_upd !== 1'b1) begin bad++; $display("FAIL manual_plus_upd: got %0d want 1", scale_upd); end
         step();
         total++; if (scale_upd !== 1'b0) begin bad++; $display("FAIL manual_upd_width: got %0d want 0", scale_upd); end
      end
      minus_pulse = 1'b1;
      step();
      minus_pulse = 1'b0;
      total++; if (scale !== 6'd2)     begin bad++; $display("FAIL manual_minus_scale: got %0d want 2", scale); end
      total++; if (scale_upd !== 1'b1) begin bad++; $display("FAIL manual_minus_upd: got %0d want 1", scale_upd); end
      total++; if (sweep_dir !== 1'b1) begin bad++; $display("FAIL manual_dir: got %0d want 1", sweep_dir); end
   endtask

   task automatic test_saturation();
      int upd_cnt;
      do_reset();
      minus_pulse = 1'b1;
      step();
      minus_pulse = 1'b0;
      total++; if (scale !== 6'd0 || scale_upd !== 1'b0) begin bad++; $display("FAIL sat_min: got scale %0d upd %0d want 0/0", scale, scale_upd); end
      upd_cnt = 0;
      for (int i = 0; i < 70; i++) begin
         plus_pulse = 1'b1;
         step();
         if (scale_upd === 1'b1) upd_cnt++;
         plus_pulse = 1'b0;
         step();
         if (scale_upd === 1'b1) upd_cnt++;
      end
      total++; if (scale !== 6'd63) begin bad++; $display("FAIL sat_max_scale: got %0d want 63", scale); end
      total++; if (upd_cnt != 63)   begin bad++; $display("FAIL sat_upd_count: got %0d want 63", upd_cnt); end
      plus_pulse = 1'b1; minus_pulse = 1'b1;
      step();
      plus_pulse = 1'b0; minus_pulse = 1'b0;
      total++; if (scale !== 6'd63 || scale_upd !== 1'b0) begin bad++; $display("FAIL simultaneous: got scale %0d upd %0d want 63/0", scale, scale_upd); end
   endtask

   task automatic test_auto();
      do_reset();
      press_plus(5);
      auto_en = 1'b1;
      step();
      total++; if (scale !== 6'd5 || sweep_dir !== 1'b1 || scale_upd !== 1'b0) begin bad++; $display("FAIL auto_enter: got scale %0d dir %0d upd %0d want 5/1/0", scale, sweep_dir, scale_upd); end
      repeat (3) step();
      total++; if (scale !== 6'd5) begin bad++; $display("FAIL auto_dwell: got %0d want 5", scale); end
      step();
      total++; if (scale !== 6'd6 || scale_upd !== 1'b1) begin bad++; $display("FAIL auto_step1: got scale %0d upd %0d want 6/1", scale, scale_upd); end
      repeat (3) step();
      total++; if (scale !== 6'd6) begin bad++; $display("FAIL auto_dwell2: got %0d want 6", scale); end
      step();
      total++; if (scale !== 6'd7) begin bad++; $display("FAIL auto_step2: got %0d want 7", scale); end
      hold = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         total++; if (scale !== 6'd7 || scale_upd !== 1'b0) begin bad++; $display("FAIL hold_frozen: got scale %0d upd %0d want 7/0", scale, scale_upd); end
      end
      hold = 1'b0;
      repeat (3) step();
      total++; if (scale !== 6'd7) begin bad++; $display("FAIL hold_release_dwell: got %0d want 7", scale); end
      step();
      total++; if (scale !== 6'd8) begin bad++; $display("FAIL hold_release_step: got %0d want 8", scale); end
   endtask

   task automatic test_boundary();
      logic [5:0] exp1, exp2;
      logic       dir1;
`ifdef SCALE_SWEEP_PINGPONG_EN
      exp1 = 6'd62; exp2 = 6'd61; dir1 = 1'b0;
`else
      exp1 = 6'd0;  exp2 = 6'd1;  dir1 = 1'b1;
`endif
      do_reset();
      press_plus(63);
      auto_en = 1'b1;
      step();
      repeat (4) step();
      total++; if (scale !== exp1)     begin bad++; $display("FAIL bound_scale: got %0d want %0d", scale, exp1); end
      total++; if (sweep_dir !== dir1) begin bad++; $display("FAIL bound_dir: got %0d want %0d", sweep_dir, dir1); end
      total++; if (scale_upd !== 1'b1) begin bad++; $display("FAIL bound_upd: got %0d want 1", scale_upd); end
      repeat (4) step();
      total++; if (scale !== exp2)     begin bad++; $display("FAIL bound_next: got %0d want %0d", scale, exp2); end
   endtask

   task automatic test_button_tc();
      do_reset();
      press_plus(10);
      auto_en = 1'b1;
      step();
      repeat (3) step();
      minus_pulse = 1'b1;
      step();
      minus_pulse = 1'b0;
      total++; if (scale !== 6'd10 || sweep_dir !== 1'b0 || scale_upd !== 1'b0) begin bad++; $display("FAIL btn_tc: got scale %0d dir %0d upd %0d want 10/0/0", scale, sweep_dir, scale_upd); end
      repeat (3) step();
      total++; if (scale !== 6'd10) begin bad++; $display("FAIL btn_tc_dwell: got %0d want 10", scale); end
      step();
      total++; if (scale !== 6'd9 || sweep_dir !== 1'b0) begin bad++; $display("FAIL btn_tc_step: got scale %0d dir %0d want 9/0", scale, sweep_dir); end
   endtask

   task automatic test_reset_mid();
      int upd_cnt;
      do_reset();
      press_plus(20);
      auto_en = 1'b1;
      step();
      step();
      step();
      total++; if (scale !== 6'd20) begin bad++; $display("FAIL mid_pre: got %0d want 20", scale); end
      #2 reset = 1'b0;
      #1;
      total++; if (scale !== 6'd0 || sweep_dir !== 1'b1 || scale_upd !== 1'b0) begin bad++; $display("FAIL mid_reset: got scale %0d dir %0d upd %0d want 0/1/0", scale, sweep_dir, scale_upd); end
      auto_en = 1'b0;
      step();
      reset = 1'b1;
      upd_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (scale_upd !== 1'b0) upd_cnt++;
      end
      total++; if (upd_cnt != 0 || scale !== 6'd0) begin bad++; $display("FAIL mid_release: got upd pulses %0d scale %0d want 0/0", upd_cnt, scale); end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_saturation();
      test_auto();
      test_boundary();
      test_button_tc();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
